// File: rtl/polibot_pkg.sv
// ============================================================================
// Module  : polibot_pkg
// Purpose : Constants shared by the Rubik's Polibot serial front end and main
//           controller: receiver FSM state codes (identical to the codes shown
//           on the hexa7seg debug display) and protocol characters.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package polibot_pkg;

    // Receiver FSM states; the encoding is exported unchanged on db_estado.
    localparam logic [3:0] OCIOSO   = 4'h0;
    localparam logic [3:0] INICIO   = 4'h1;
    localparam logic [3:0] DADOS    = 4'h2;
    localparam logic [3:0] PARIDADE = 4'h3;
    localparam logic [3:0] PARADA   = 4'h4;

    // Host opens a cube-state transfer with 'S'.
    localparam logic [7:0] START_CHAR = 8'h53;

endpackage : polibot_pkg

`default_nettype wire

// File: rtl/receptor_serial_fifo_fifo.sv
// ============================================================================
// Module  : fifo_sincrona
// Purpose : Synchronous circular FIFO with show-ahead output register.
//           o_dout always presents the head entry while not empty; when the
//           FIFO drains it keeps the last value shown.
// Ports   : clk      - clock, rising edge
//           rst      - synchronous active-high reset
//           i_push   - write i_din (accepted if not full, or if full and a
//                      pop happens in the same cycle)
//           i_pop    - remove head entry (ignored while empty)
//           i_din    - write data
//           o_dout   - head entry (registered)
//           o_full   - DEPTH entries held
//           o_empty  - no entries held
// Params  : WIDTH (data bits), DEPTH (entries, power of two, >= 2)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_sincrona #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);
    localparam logic [CW-1:0] c_one   = CW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;

    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;
    logic [AW-1:0]    w_rd_next;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_depth);
    assign w_do_pop  = i_pop && !w_empty;
    // A pop frees the slot this same cycle, so a full FIFO still accepts.
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign w_rd_next = r_rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end

            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase

            // Show-ahead: load the entry that becomes the head next cycle.
            if (w_do_pop) begin
                if (r_count == c_one) begin
                    // Last entry leaves; a simultaneous push becomes the head,
                    // otherwise the output keeps its final value.
                    if (w_do_push) begin
                        r_dout <= i_din;
                    end
                end else begin
                    r_dout <= r_mem[w_rd_next];
                end
            end else if (w_do_push && w_empty) begin
                r_dout <= i_din;
            end
        end
    end

    assign o_dout  = r_dout;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule : fifo_sincrona

`default_nettype wire

// File: rtl/receptor_serial_fifo.sv
// ============================================================================
// Module  : receptor_serial_fifo
// Purpose : UART receiver (8N1, or 8E1 when RECEPTOR_PARIDADE_EN is defined)
//           feeding a small byte FIFO read by the Polibot main controller.
// Ports   : clock       - system clock, rising edge
//           reset       - synchronous active-low reset
//           rx_serial   - asynchronous serial line, idle high
//           dado        - FIFO head byte (qualify with dado_valido)
//           dado_valido - FIFO not empty
//           dado_ler    - pop strobe, ignored while empty
//           fifo_cheia  - FIFO full
//           erro_quadro - one-cycle pulse on a bad frame
//           overflow    - sticky, byte lost because FIFO was full
//           db_estado   - receiver FSM code for the 7-segment debug display
// Params  : CLK_FREQ (Hz), BAUD (bit/s), FIFO_DEPTH (power of two, >= 2)
// Macro   : RECEPTOR_PARIDADE_EN - enables the even-parity bit (8E1 frame)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module receptor_serial_fifo
    import polibot_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_serial,
    output logic [7:0] dado,
    output logic       dado_valido,
    input  logic       dado_ler,
    output logic       fifo_cheia,
    output logic       erro_quadro,
    output logic       overflow,
    output logic [3:0] db_estado
);

    localparam int CPB = CLK_FREQ / BAUD;
    localparam int TW  = $clog2(CPB);
    localparam logic [TW-1:0] c_half = TW'(CPB / 2);
    localparam logic [TW-1:0] c_last = TW'(CPB - 1);

    logic          r_sync1;
    logic          r_rx_s;
    logic [3:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_erro;
    logic          r_overflow;
`ifdef RECEPTOR_PARIDADE_EN
    logic          r_par;
`endif

    logic          w_rst;
    logic          w_mid;
    logic          w_end;
    logic          w_frame_ok;
    logic          w_stop_sample;
    logic          w_push;
    logic          w_full;
    logic          w_empty;
    logic          w_overflow_evt;

    assign w_rst = ~reset;
    assign w_mid = (r_timer == c_half);
    assign w_end = (r_timer == c_last);

`ifdef RECEPTOR_PARIDADE_EN
    // Even parity: the parity bit equals the XOR of the data bits.
    assign w_frame_ok = r_rx_s && ((^r_shift) == r_par);
`else
    assign w_frame_ok = r_rx_s;
`endif

    assign w_stop_sample  = (r_state == PARADA) && w_mid;
    assign w_push         = w_stop_sample && w_frame_ok;
    // When full, the controller's pop in the same cycle makes room.
    assign w_overflow_evt = w_push && w_full && !dado_ler;

    // Two-flop synchroniser, reset to the idle (high) line level.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= OCIOSO;
            r_timer    <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_erro     <= 1'b0;
            r_overflow <= 1'b0;
`ifdef RECEPTOR_PARIDADE_EN
            r_par      <= 1'b0;
`endif
        end else begin
            r_erro <= 1'b0;
            case (r_state)
                OCIOSO: begin
                    if (!r_rx_s) begin
                        r_timer <= '0;
                        r_state <= INICIO;
                    end
                end
                INICIO: begin
                    if (w_mid && r_rx_s) begin
                        // Start bit gone by mid-bit: line glitch.
                        r_timer <= '0;
                        r_state <= OCIOSO;
                    end else if (w_end) begin
                        r_timer <= '0;
                        r_idx   <= '0;
                        r_state <= DADOS;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                DADOS: begin
                    if (w_mid) begin
                        r_shift[r_idx] <= r_rx_s;
                    end
                    if (w_end) begin
                        r_timer <= '0;
                        if (r_idx == 3'd7) begin
`ifdef RECEPTOR_PARIDADE_EN
                            r_state <= PARIDADE;
`else
                            r_state <= PARADA;
`endif
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
`ifdef RECEPTOR_PARIDADE_EN
                PARIDADE: begin
                    if (w_mid) begin
                        r_par <= r_rx_s;
                    end
                    if (w_end) begin
                        r_timer <= '0;
                        r_state <= PARADA;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
`endif
                PARADA: begin
                    // Leave at mid stop bit so the next start edge is caught
                    // even if the sender's clock runs slightly fast.
                    if (w_mid) begin
                        r_timer <= '0;
                        r_state <= OCIOSO;
                        if (!w_frame_ok) begin
                            r_erro <= 1'b1;
                        end
                        if (w_overflow_evt) begin
                            r_overflow <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_timer <= '0;
                    r_state <= OCIOSO;
                end
            endcase
        end
    end

    fifo_sincrona #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (w_rst),
        .i_push  (w_push),
        .i_pop   (dado_ler),
        .i_din   (r_shift),
        .o_dout  (dado),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign dado_valido = !w_empty;
    assign fifo_cheia  = w_full;
    assign erro_quadro = r_erro;
    assign overflow    = r_overflow;
    assign db_estado   = r_state;

endmodule : receptor_serial_fifo

`default_nettype wire

// File: tb/tb_receptor_serial_fifo.sv
// ============================================================================
// Module  : tb_receptor_serial_fifo
// Purpose : Directed self-checking bench for receptor_serial_fifo (8N1 build)
//           with CLK_FREQ = 1000, BAUD = 100, i.e. 10 clocks per bit.
//           Inputs change 1 time unit after a rising edge; outputs are
//           checked at the same point.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_receptor_serial_fifo;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] dado;
    logic       dado_valido;
    logic       dado_ler;
    logic       fifo_cheia;
    logic       erro_quadro;
    logic       overflow;
    logic [3:0] db_estado;

    int n_total  = 0;
    int n_passed = 0;
    int n_failed = 0;
    int err_cycles = 0;

    receptor_serial_fifo #(
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clock       (clk),
        .reset       (reset),
        .rx_serial   (rx),
        .dado        (dado),
        .dado_valido (dado_valido),
        .dado_ler    (dado_ler),
        .fifo_cheia  (fifo_cheia),
        .erro_quadro (erro_quadro),
        .overflow    (overflow),
        .db_estado   (db_estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; count cycles with erro_quadro high.
    task automatic tick();
        @(posedge clk);
        #1;
        if (erro_quadro === 1'b1) err_cycles++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else begin
            n_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One frame starting now; returns 100 clocks later with the line idle.
    // With pop_at_stop the read strobe coincides with the stop-bit sample.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pop_at_stop);
        rx = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (10) tick();
        end
        rx = stop;
        repeat (8) tick();
        if (pop_at_stop) dado_ler = 1'b1;
        tick();
        dado_ler = 1'b0;
        tick();
        rx = 1'b1;
    endtask

    task automatic pop();
        dado_ler = 1'b1;
        tick();
        dado_ler = 1'b0;
    endtask

    initial begin
        logic [7:0] seq [4];
        logic [7:0] d55;

        reset    = 1'b0;
        rx       = 1'b1;
        dado_ler = 1'b0;
        repeat (2) tick();

        // ---- reset state ----
        chk("rst_dado",    32'(dado), 32'h00);
        chk("rst_valido",  32'(dado_valido), 32'd0);
        chk("rst_cheia",   32'(fifo_cheia), 32'd0);
        chk("rst_erro",    32'(erro_quadro), 32'd0);
        chk("rst_ovf",     32'(overflow), 32'd0);
        chk("rst_estado",  32'(db_estado), 32'h0);
        reset = 1'b1;
        repeat (5) tick();

        // ---- 1: single byte 0x55, state trace and latency ----
        d55 = 8'h55;
        rx = 1'b0;
        repeat (2) tick();
        chk("t1_ocioso",  32'(db_estado), 32'h0);
        tick();
        chk("t1_inicio",  32'(db_estado), 32'h1);
        repeat (7) tick();
        rx = d55[0];
        repeat (3) tick();
        chk("t1_dados",   32'(db_estado), 32'h2);
        repeat (7) tick();
        for (int i = 1; i < 8; i++) begin
            rx = d55[i];
            repeat (10) tick();
        end
        rx = 1'b1;
        repeat (3) tick();
        chk("t1_parada",  32'(db_estado), 32'h4);
        repeat (5) tick();
        chk("t1_valido_early", 32'(dado_valido), 32'd0);
        tick();
        chk("t1_valido",  32'(dado_valido), 32'd1);
        chk("t1_dado",    32'(dado), 32'h55);
        chk("t1_back_ocioso", 32'(db_estado), 32'h0);
        tick();
        pop();
        chk("t1_empty",   32'(dado_valido), 32'd0);
        chk("t1_hold",    32'(dado), 32'h55);

        // ---- 2: fill, overflow, ordered drain ----
        send_frame(8'h52, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'h46, 1'b1, 1'b0);
        chk("t2_not_full3", 32'(fifo_cheia), 32'd0);
        send_frame(8'h42, 1'b1, 1'b0);
        chk("t2_full",    32'(fifo_cheia), 32'd1);
        chk("t2_no_ovf",  32'(overflow), 32'd0);
        send_frame(8'h4C, 1'b1, 1'b0);
        chk("t2_ovf",     32'(overflow), 32'd1);
        seq[0] = 8'h52; seq[1] = 8'h55; seq[2] = 8'h46; seq[3] = 8'h42;
        for (int i = 0; i < 4; i++) begin
            chk("t2_pop_valid", 32'(dado_valido), 32'd1);
            chk("t2_pop_data",  32'(dado), 32'(seq[i]));
            pop();
        end
        chk("t2_drained", 32'(dado_valido), 32'd0);
        chk("t2_ovf_sticky", 32'(overflow), 32'd1);

        // ---- 3: framing error ----
        err_cycles = 0;
        send_frame(8'hA3, 1'b0, 1'b0);
        repeat (20) tick();
        chk("t3_err_pulse", 32'(err_cycles), 32'd1);
        chk("t3_no_data",   32'(dado_valido), 32'd0);
        chk("t3_ocioso",    32'(db_estado), 32'h0);

        // ---- 4: 3-cycle glitch ----
        err_cycles = 0;
        rx = 1'b0;
        repeat (3) tick();
        chk("t4_inicio", 32'(db_estado), 32'h1);
        rx = 1'b1;
        repeat (5) tick();
        chk("t4_still_inicio", 32'(db_estado), 32'h1);
        tick();
        chk("t4_abort", 32'(db_estado), 32'h0);
        repeat (20) tick();
        chk("t4_no_data", 32'(dado_valido), 32'd0);
        chk("t4_no_err",  32'(err_cycles), 32'd0);

        // Clear sticky overflow.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rst2_ovf", 32'(overflow), 32'd0);
        repeat (3) tick();

        // ---- 5: push while full with simultaneous pop ----
        send_frame(8'hC1, 1'b1, 1'b0);
        send_frame(8'hC2, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        send_frame(8'hC4, 1'b1, 1'b0);
        chk("t5_full",  32'(fifo_cheia), 32'd1);
        send_frame(8'h11, 1'b1, 1'b1);
        chk("t5_no_ovf",    32'(overflow), 32'd0);
        chk("t5_still_full", 32'(fifo_cheia), 32'd1);
        seq[0] = 8'hC2; seq[1] = 8'hC3; seq[2] = 8'hC4; seq[3] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            chk("t5_pop_data", 32'(dado), 32'(seq[i]));
            pop();
        end
        chk("t5_drained", 32'(dado_valido), 32'd0);

        // ---- 6: reset in the middle of DADOS, then clean byte ----
        rx = 1'b0;
        repeat (10) tick();
        rx = 1'b1;
        repeat (10) tick();
        rx = 1'b0;
        repeat (10) tick();
        chk("t6_in_dados", 32'(db_estado), 32'h2);
        reset = 1'b0;
        rx    = 1'b1;
        tick();
        reset = 1'b1;
        chk("t6_rst_dado",   32'(dado), 32'h00);
        chk("t6_rst_valido", 32'(dado_valido), 32'd0);
        chk("t6_rst_estado", 32'(db_estado), 32'h0);
        chk("t6_rst_ovf",    32'(overflow), 32'd0);
        repeat (20) tick();
        err_cycles = 0;
        send_frame(8'h7E, 1'b1, 1'b0);
        chk("t6_valido", 32'(dado_valido), 32'd1);
        chk("t6_dado",   32'(dado), 32'h7E);
        chk("t6_no_err", 32'(err_cycles), 32'd0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule : tb_receptor_serial_fifo

`default_nettype wire
